h_write_burst_ctrl: RTL and testbench
=====================================

H_WRITE_BURST_CTRL -- requirements
Module: h_write_burst_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; resetn  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have AXI AW ports: aw_valid in 1; aw_ready out 1; aw_addr in 32; aw_len in 4 (beats-1); aw_size in 3; aw_burst in 2 (00 FIXED, 01 INCR, 10 WRAP).
REQ-003 SHALL have AXI W ports: w_valid in 1; w_ready out 1; w_data in 32; w_strb in 4 (unused, 32-bit bus); w_last in 1.
REQ-004 SHALL have AXI B ports: b_valid out 1; b_ready in 1; b_resp out 2 (00 OKAY, 10 SLVERR).
REQ-005 SHALL have AHB ports: haddr out 32; htrans out 2 (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ); hwrite out 1; hsize out 3; hwdata out 32; hready in 1; hresp in 1 (1 = ERROR).

Function
REQ-006 SHALL implement states IDLE, ADDR (first beat), BURST (beats 2..N), LAST_DATA (final data phase), DRAIN (error absorb), RESP.
REQ-007 IDLE: aw_ready=1; on aw_valid capture addr/len/size/burst, clear beat count and error flag; go ADDR, or DRAIN if request illegal.
REQ-008 Illegal request: aw_size>2, aw_burst=11, or WRAP with aw_len not in {1,3,7,15}.
REQ-009 ADDR/BURST: w_ready=hready; beat transfers when w_valid&w_ready; htrans=NONSEQ (ADDR) / SEQ (BURST) when w_valid, else IDLE (ADDR) / BUSY (BURST).
REQ-010 haddr SHALL equal the address of the current beat; hsize=captured size; hwrite=1 whenever htrans is NONSEQ/SEQ/BUSY, else 0.
REQ-011 Beat address: FIXED = base; INCR = base + beat*2^size (32-bit wrap-around modulo 2^32); WRAP = boundary-aligned wrap within window 2^size*(len+1).
REQ-012 On each beat transfer, hwdata register SHALL load w_data, valid in the following cycle (AHB data phase), and hold until the next transfer.
REQ-013 After beat transfer with beat count == len, go LAST_DATA; otherwise ADDR->BURST, BURST stays; beat count increments per transfer.
REQ-014 LAST_DATA: htrans=IDLE, w_ready=0; on hready=1 go RESP.
REQ-015 hresp=1 sampled with hready=1 during any data phase SHALL set sticky error flag; burst continues to completion.
REQ-016 w_last mismatch (asserted before beat len, or deasserted on beat len) SHALL set error flag; beat count, not w_last, terminates burst.
REQ-017 DRAIN: htrans=IDLE, w_ready=1; accept W beats until w_last or len+1 beats; then RESP with SLVERR.
REQ-018 RESP: b_valid=1, b_resp=SLVERR if error flag else OKAY; on b_ready go IDLE; aw_ready=0 until back in IDLE.
REQ-019 hready=0 stalls: w_ready=0, haddr/htrans/hwdata held; no beat advance.
REQ-020 Latency: AW accept to first NONSEQ = 1 cycle; last beat accept to b_valid = 1 cycle after final hready.

Reset
REQ-021 resetn low SHALL force state IDLE, beat count 0, error flag 0, hwdata 0, captured fields 0.
REQ-022 While resetn low: aw_ready=0, w_ready=0, b_valid=0, b_resp=00, htrans=IDLE, hwrite=0, haddr=0.
REQ-023 Reset mid-burst SHALL abandon the burst with no B response generated.

Structure
REQ-024 Package h_bridge_pkg SHALL hold burst-type, htrans and resp encodings plus the state enum.
REQ-025 Beat-address arithmetic SHALL be a sub-module h_addr_write_count (inputs base, len, size, burst, beat; output addr).

Verification
REQ-026 INCR aw_addr=0x1000, len=3, size=2, continuous w_valid, hready=1 -> haddr 0x1000/04/08/0C, htrans NONSEQ,SEQ,SEQ,SEQ; b_resp=OKAY.
REQ-027 WRAP aw_addr=0x2038, len=3, size=2 -> haddr 0x2038,0x203C,0x2030,0x2034.
REQ-028 INCR len=1 with w_valid gap after beat 0 -> htrans BUSY during gap, haddr held at 0x1004.
REQ-029 hresp=1 on beat 2 of len=3 burst -> all 4 beats issued; b_resp=SLVERR.
REQ-030 aw_size=3, len=1 -> no AHB NONSEQ; 2 W beats accepted; b_resp=SLVERR.
REQ-031 hready=0 for 3 cycles mid-burst, then resetn pulse -> outputs held during stall, then reset values; no b_valid.

Source files
------------

// File: rtl/h_bridge_pkg.sv
// Shared encodings for the AXI-write to AHB bridge: burst types, htrans, resp, FSM states.
// Also holds the legality check applied to incoming AW requests.
package h_bridge_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_BURST     = 3'd2,
        ST_LAST_DATA = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_RESP      = 3'd5
    } state_e;

    // Oversized beats, reserved burst type, or a wrap length that is not a power of two.
    function automatic logic req_illegal(input logic [3:0] len,
                                         input logic [2:0] size,
                                         input logic [1:0] burst);
        logic ill;
        ill = (size > 3'd2) || (burst == BURST_RSVD);
        if (burst == BURST_WRAP) begin
            ill = ill || !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
        end else begin
            ill = ill;
        end
        return ill;
    endfunction

endpackage

// File: rtl/h_addr_write_count.sv
// Beat address generator: maps (base, len, size, burst, beat index) to the AHB address.
module h_addr_write_count
    import h_bridge_pkg::*;
(
    input  logic [31:0] base,
    input  logic [3:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    input  logic [3:0]  beat,
    output logic [31:0] addr
);

    logic [31:0] w_lin;
    logic [31:0] w_mask;

    // Linear offset and wrap-window mask; WRAP keeps the window-aligned upper bits of base.
    always_comb begin
        w_lin  = base + ({28'd0, beat} << size);
        w_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: addr = base;
            BURST_INCR:  addr = w_lin;
            BURST_WRAP:  addr = (base & ~w_mask) | (w_lin & w_mask);
            default:     addr = base;
        endcase
    end

endmodule

// File: rtl/h_write_burst_ctrl.sv
// AXI write-burst to AHB master bridge: one outstanding burst, beats paced by w_valid and hready,
// illegal requests drained on W and answered with SLVERR.
module h_write_burst_ctrl
    import h_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        aw_valid,
    output logic        aw_ready,
    input  logic [31:0] aw_addr,
    input  logic [3:0]  aw_len,
    input  logic [2:0]  aw_size,
    input  logic [1:0]  aw_burst,
    input  logic        w_valid,
    output logic        w_ready,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    input  logic        w_last,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [1:0]  b_resp,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic        hresp
);

    state_e      r_state;
    logic [31:0] r_base;
    logic [3:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [3:0]  r_beat;
    logic        r_err;
    logic        r_dphase;
    logic [31:0] r_hwdata;

    logic        w_xfer;
    logic        w_last_beat;
    logic        w_dp_err;
    logic        w_unused;

    h_addr_write_count u_addr (
        .base  (r_base),
        .len   (r_len),
        .size  (r_size),
        .burst (r_burst),
        .beat  (r_beat),
        .addr  (haddr)
    );

    assign w_xfer      = ((r_state == ST_ADDR) || (r_state == ST_BURST)) && w_valid && hready;
    assign w_last_beat = (r_beat == r_len);
    // A data phase completes on the first hready after its beat; hresp is only meaningful then.
    assign w_dp_err    = r_dphase && hready && hresp;
    assign w_unused    = ^w_strb;

    assign hsize  = r_size;
    assign hwdata = r_hwdata;
    assign hwrite = (htrans != HTRANS_IDLE);

    // Handshake and AHB control decode from the current state and live w_valid/hready.
    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        htrans   = HTRANS_IDLE;
        b_valid  = 1'b0;
        b_resp   = RESP_OKAY;
        case (r_state)
            ST_IDLE:  aw_ready = resetn;
            ST_ADDR: begin
                w_ready = hready;
                htrans  = w_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
            end
            ST_BURST: begin
                w_ready = hready;
                htrans  = w_valid ? HTRANS_SEQ : HTRANS_BUSY;
            end
            ST_DRAIN: w_ready = 1'b1;
            ST_RESP: begin
                b_valid = 1'b1;
                b_resp  = r_err ? RESP_SLVERR : RESP_OKAY;
            end
            default: aw_ready = 1'b0;
        endcase
    end

    // Burst sequencing, beat counting, sticky error and write-data register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_base   <= 32'd0;
            r_len    <= 4'd0;
            r_size   <= 3'd0;
            r_burst  <= 2'b00;
            r_beat   <= 4'd0;
            r_err    <= 1'b0;
            r_dphase <= 1'b0;
            r_hwdata <= 32'd0;
        end else begin
            r_dphase <= w_xfer ? 1'b1 : (hready ? 1'b0 : r_dphase);
            case (r_state)
                ST_IDLE: begin
                    if (aw_valid) begin
                        r_base  <= aw_addr;
                        r_len   <= aw_len;
                        r_size  <= aw_size;
                        r_burst <= aw_burst;
                        r_beat  <= 4'd0;
                        r_err   <= req_illegal(aw_len, aw_size, aw_burst);
                        r_state <= req_illegal(aw_len, aw_size, aw_burst) ? ST_DRAIN : ST_ADDR;
                    end
                end
                ST_ADDR, ST_BURST: begin
                    if (w_dp_err) begin
                        r_err <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_hwdata <= w_data;
                        r_beat   <= r_beat + 4'd1;
                        if (w_last != w_last_beat) begin
                            r_err <= 1'b1;
                        end
                        r_state  <= w_last_beat ? ST_LAST_DATA : ST_BURST;
                    end
                end
                ST_LAST_DATA: begin
                    if (hready) begin
                        if (hresp) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_DRAIN: begin
                    if (w_valid) begin
                        r_beat <= r_beat + 4'd1;
                        if (w_last || w_last_beat) begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (b_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_h_write_burst_ctrl.sv
// Self-checking bench: directed scenarios plus random bursts, checked against an arithmetic model.
module tb_h_write_burst_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [31:0] aw_addr = 32'd0;
    logic [3:0]  aw_len = 4'd0;
    logic [2:0]  aw_size = 3'd0;
    logic [1:0]  aw_burst = 2'd0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [31:0] w_data = 32'd0;
    logic [3:0]  w_strb = 4'hF;
    logic        w_last = 1'b0;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_hwdata = 32'd0;

    h_write_burst_ctrl dut (
        .clk(clk), .resetn(resetn),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_illegal(input int len, input int sz, input int bt);
        return (sz > 2) || (bt == 3) || ((bt == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // Address of beat k: fixed, linear, or modulo a window of (len+1) beats.
    function automatic logic [31:0] m_addr(input logic [31:0] a, input int len, input int sz,
                                           input int bt, input int k);
        logic [31:0] bytes, win, lo;
        bytes = 32'd1 << sz;
        if (bt == 0) return a;
        if (bt == 1) return a + bytes * 32'(k);
        win = 32'(len + 1) * bytes;
        lo  = a - (a % win);
        return lo + ((a - lo + bytes * 32'(k)) % win);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_aw_ready"}, aw_ready, 0);
        chk({tag, "_w_ready"}, w_ready, 0);
        chk({tag, "_b_valid"}, b_valid, 0);
        chk({tag, "_b_resp"}, b_resp, 0);
        chk({tag, "_htrans"}, htrans, 0);
        chk({tag, "_hwrite"}, hwrite, 0);
        chk({tag, "_haddr"}, haddr, 0);
        chk({tag, "_hwdata"}, hwdata, 0);
    endtask

    // One complete AW/W/B transaction; err_beat selects whose data phase gets hresp (99 = none).
    task automatic run_burst(input logic [31:0] a, input int len, input int sz, input int bt,
                             input int gap_pct, input int stall_pct, input int err_beat,
                             input bit early_last);
        bit          exp_err;
        int          pend;
        int          nb;
        logic [31:0] ad;
        logic [31:0] d;
        logic [1:0]  tr;
        aw_valid = 1'b1; aw_addr = a; aw_len = 4'(len); aw_size = 3'(sz); aw_burst = 2'(bt);
        w_valid = 1'b0; w_last = 1'b0; hready = 1'b1; hresp = 1'b0; b_ready = 1'b0;
        #1;
        chk("aw_ready_idle", aw_ready, 1);
        step();
        aw_valid = 1'b0;
        if (m_illegal(len, sz, bt)) begin
            nb = early_last ? 1 : len + 1;
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(99) < gap_pct) begin
                    w_valid = 1'b0; #1;
                    chk("drain_wready_gap", w_ready, 1);
                    step();
                end
                w_valid = 1'b1; w_data = $urandom; w_last = (k == nb - 1); #1;
                chk("drain_wready", w_ready, 1);
                chk("drain_htrans", htrans, 0);
                chk("drain_hwrite", hwrite, 0);
                chk("drain_no_b", b_valid, 0);
                step();
            end
            exp_err = 1'b1;
        end else begin
            exp_err = (early_last && len != 0) || (err_beat <= len);
            pend = -1;
            for (int k = 0; k <= len; k++) begin
                ad = m_addr(a, len, sz, bt, k);
                tr = (k == 0) ? 2'b10 : 2'b11;
                d  = $urandom;
                if ($urandom_range(99) < gap_pct) begin
                    w_valid = 1'b0; hready = 1'b1;
                    hresp = (pend >= 0) && (pend == err_beat); pend = -1; #1;
                    chk("gap_htrans", htrans, (k == 0) ? 2'b00 : 2'b01);
                    chk("gap_haddr", haddr, ad);
                    chk("gap_hwrite", hwrite, (k != 0));
                    step();
                end
                if ($urandom_range(99) < stall_pct) begin
                    for (int s = 0; s < 3; s++) begin
                        w_valid = 1'b1; w_data = d; hready = 1'b0; hresp = 1'b0; #1;
                        chk("stall_wready", w_ready, 0);
                        chk("stall_htrans", htrans, tr);
                        chk("stall_haddr", haddr, ad);
                        chk("stall_hwdata", hwdata, exp_hwdata);
                        step();
                    end
                end
                w_valid = 1'b1; w_data = d; hready = 1'b1;
                hresp = (pend >= 0) && (pend == err_beat); pend = -1;
                w_last = early_last ? 1'b1 : (k == len); #1;
                chk("beat_wready", w_ready, 1);
                chk("beat_htrans", htrans, tr);
                chk("beat_haddr", haddr, ad);
                chk("beat_hwrite", hwrite, 1);
                chk("beat_hsize", hsize, 32'(sz));
                step();
                exp_hwdata = d; pend = k;
                chk("beat_hwdata", hwdata, exp_hwdata);
            end
            w_valid = 1'b0; w_last = 1'b0;
            if ($urandom_range(99) < stall_pct) begin
                hready = 1'b0; hresp = 1'b0; #1;
                chk("last_stall_htrans", htrans, 0);
                chk("last_stall_wready", w_ready, 0);
                chk("last_stall_no_b", b_valid, 0);
                step();
            end
            hready = 1'b1; hresp = (pend == err_beat); #1;
            chk("last_htrans", htrans, 0);
            chk("last_wready", w_ready, 0);
            chk("last_no_b", b_valid, 0);
            step();
            hresp = 1'b0;
        end
        w_valid = 1'b0; w_last = 1'b0;
        chk("b_valid", b_valid, 1);
        chk("b_resp", b_resp, exp_err ? 2'b10 : 2'b00);
        chk("resp_aw_ready", aw_ready, 0);
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("b_hold", b_valid, 1);
        end
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        chk("b_done", b_valid, 0);
        chk("back_idle_aw_ready", aw_ready, 1);
    endtask

    initial begin
        logic [31:0] d0;
        logic [31:0] d1;
        int len, sz, bt;
        // Reset state, then release.
        #2;
        check_reset_outputs("rst");
        step();
        step();
        resetn = 1'b1;
        #1;
        chk("post_rst_aw_ready", aw_ready, 1);

        // INCR 4 beats from 0x1000, no gaps or stalls.
        run_burst(32'h1000, 3, 2, 1, 0, 0, 99, 1'b0);
        // WRAP 4 beats starting mid-window.
        run_burst(32'h2038, 3, 2, 2, 0, 0, 99, 1'b0);
        // INCR 2 beats with a w_valid gap before every beat.
        run_burst(32'h1000, 1, 2, 1, 100, 0, 99, 1'b0);
        // Error response on beat 2's data phase; all beats still issued.
        run_burst(32'h4000, 3, 2, 1, 0, 0, 2, 1'b0);
        // Error on the final beat's data phase, with stalls.
        run_burst(32'h4100, 3, 1, 1, 0, 100, 3, 1'b0);
        // Oversized beats: drained, SLVERR.
        run_burst(32'h5000, 1, 3, 1, 0, 0, 99, 1'b0);
        // Early w_last on a legal burst.
        run_burst(32'h6000, 2, 2, 1, 0, 0, 99, 1'b1);
        // Single-beat FIXED, and address wrap-around at the top of the space.
        run_burst(32'h7000, 0, 0, 0, 0, 0, 99, 1'b0);
        run_burst(32'hFFFF_FFF8, 3, 2, 1, 0, 0, 99, 1'b0);
        // Illegal WRAP length, drain ended early by w_last.
        run_burst(32'h8000, 2, 2, 2, 0, 0, 99, 1'b1);

        for (int n = 0; n < 30; n++) begin
            bt  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            sz  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            len = $urandom_range(0, 15);
            if (bt == 2 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            run_burst($urandom & ~((32'd1 << sz) - 32'd1), len, sz, bt, 30, 30,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 99,
                      ($urandom_range(0, 7) == 0));
        end

        // Stall mid-burst, then reset: outputs hold, then reset values, and no response.
        aw_valid = 1'b1; aw_addr = 32'h3000; aw_len = 4'd3; aw_size = 3'd2; aw_burst = 2'd1;
        step();
        aw_valid = 1'b0;
        d0 = $urandom; d1 = $urandom;
        w_valid = 1'b1; w_data = d0; hready = 1'b1;
        step();
        w_data = d1;
        step();
        w_data = $urandom; hready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("rst_stall_htrans", htrans, 2'b11);
            chk("rst_stall_haddr", haddr, 32'h3008);
            chk("rst_stall_hwdata", hwdata, d1);
            chk("rst_stall_wready", w_ready, 0);
            step();
        end
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        w_valid = 1'b0; hready = 1'b1;
        step();
        step();
        resetn = 1'b1;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk("midrst_no_b", b_valid, 0);
            chk("midrst_aw_ready", aw_ready, 1);
            chk("midrst_htrans", htrans, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
